mult_seq_ctrl: RTL and testbench

Handshaked sequencing controller for the shift-add multiplier datapath (A/B operand registers, P accumulator, adder). It accepts a start request and issues one control strobe per cycle: clear, load operands, conditional accumulate, shift P, shift B. Iteration count is parameterised and the accumulate step can be skipped on zero multiplier bits. It signals busy/done so a top-level driver or testbench can chain multiplications.

---
 rtl/mult_ctrl_pkg.sv | 46 ++++
 rtl/mult_seq_ctrl.sv | 85 ++++++++
 tb/tb_mult_seq_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mult_ctrl_pkg.sv
// ============================================================================
// Module      : mult_ctrl_pkg
// Description : State encoding and strobe-vector layout shared by the
//               shift-add multiplier sequencing controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    LOAD = 3'd2,
    ADD  = 3'd3,
    SHP  = 3'd4,
    SHB  = 3'd5,
    DONE = 3'd6
  } state_t;

  // Strobe vector layout: {clr, shftb, shftp, loadab, loadp}
  localparam int STB_LOADP  = 0;
  localparam int STB_LOADAB = 1;
  localparam int STB_SHFTP  = 2;
  localparam int STB_SHFTB  = 3;
  localparam int STB_CLR    = 4;
  localparam int STB_W      = 5;

  // ADD reports an unconditional loadp here; the b_lsb gating happens at the port.
  function automatic logic [STB_W-1:0] state_strobes(input state_t s);
    logic [STB_W-1:0] v;
    v = '0;
    case (s)
      CLR:     v[STB_CLR]    = 1'b1;
      LOAD:    v[STB_LOADAB] = 1'b1;
      ADD:     v[STB_LOADP]  = 1'b1;
      SHP:     v[STB_SHFTP]  = 1'b1;
      SHB:     v[STB_SHFTB]  = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mult_seq_ctrl.sv
// ============================================================================
// Module      : mult_seq_ctrl
// Description : Start/busy/done sequencer issuing clear, load, accumulate and
//               shift strobes to a shift-add multiplier datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_seq_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter int N         = 4,
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic b_lsb,
  output logic clr,
  output logic loadab,
  output logic loadp,
  output logic shftp,
  output logic shftb,
  output logic busy,
  output logic done
);

  localparam int CW = $clog2(N);

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [STB_W-1:0] r_strb;
  logic             r_busy;
  logic             r_done;
  logic             w_last;

  assign w_last = (r_cnt == CW'(N - 1));

  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = start ? CLR : IDLE;
      CLR:     w_next = LOAD;
      LOAD:    w_next = ADD;
      ADD:     w_next = SHP;
      SHP:     w_next = w_last ? DONE : SHB;
      SHB:     w_next = ADD;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_strb  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == LOAD) begin
        r_cnt <= '0;
      end else if (r_state == SHB) begin
        r_cnt <= r_cnt + CW'(1);
      end
      r_strb <= state_strobes(w_next);
      r_busy <= (w_next != IDLE);
      r_done <= (w_next == DONE);
    end
  end

  assign clr    = r_strb[STB_CLR];
  assign loadab = r_strb[STB_LOADAB];
  assign loadp  = r_strb[STB_LOADP] & (b_lsb | ~SKIP_ZERO);
  assign shftp  = r_strb[STB_SHFTP];
  assign shftb  = r_strb[STB_SHFTB];
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

`default_nettype wire

// File: tb/tb_mult_seq_ctrl.sv
// ============================================================================
// Module      : tb_mult_seq_ctrl
// Description : Self-checking bench for mult_seq_ctrl against a schedule-list
//               reference model, with a second N=8 non-skipping instance.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_seq_ctrl;

  localparam int N  = 4;
  localparam bit SZ = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, b_lsb = 1'b0;
  logic clr, loadab, loadp, shftp, shftb, busy, done;
  logic start8 = 1'b0, b8 = 1'b0;
  logic clr8, loadab8, loadp8, shftp8, shftb8, busy8, done8;

  always #5 clk = ~clk;

  mult_seq_ctrl #(.N(N), .SKIP_ZERO(SZ)) dut (
    .clk(clk), .rst(rst), .start(start), .b_lsb(b_lsb),
    .clr(clr), .loadab(loadab), .loadp(loadp), .shftp(shftp),
    .shftb(shftb), .busy(busy), .done(done)
  );

  mult_seq_ctrl #(.N(8), .SKIP_ZERO(1'b0)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .b_lsb(b8),
    .clr(clr8), .loadab(loadab8), .loadp(loadp8), .shftp(shftp8),
    .shftb(shftb8), .busy(busy8), .done(done8)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One operation as a list of step letters: C L (A P B)... A P D
  byte sched[$];
  int  pos = -1;

  function automatic logic [6:0] expect_vec(input int p, input logic b);
    logic [6:0] v;  // {clr, loadab, loadp, shftp, shftb, busy, done}
    v = '0;
    if (p >= 0) begin
      v[1] = 1'b1;
      case (sched[p])
        "C": v[6] = 1'b1;
        "L": v[5] = 1'b1;
        "A": v[4] = b | ~SZ;
        "P": v[3] = 1'b1;
        "B": v[2] = 1'b1;
        "D": v[0] = 1'b1;
        default: v = '0;
      endcase
    end
    return v;
  endfunction

  task automatic tick(input string tag);
    @(posedge clk);
    if (rst) pos = -1;
    else if (pos < 0) pos = start ? 0 : -1;
    else if (pos == sched.size() - 1) pos = -1;
    else pos++;
    @(negedge clk);
    chk(tag, {25'd0, clr, loadab, loadp, shftp, shftb, busy, done},
        {25'd0, expect_vec(pos, b_lsb)});
  endtask

  function automatic bit at(input byte c);
    return (pos >= 0) && (sched[pos] == c);
  endfunction

  initial begin
    int done_cyc, lp_cnt, ai, nb, k8;
    int clr_starts[$];
    int c_lp, c_sp, c_sb, c_clr, c_dn;
    logic [3:0] pat;

    sched.push_back("C");
    sched.push_back("L");
    for (int i = 0; i < N; i++) begin
      sched.push_back("A");
      sched.push_back("P");
      if (i < N - 1) sched.push_back("B");
    end
    sched.push_back("D");

    // Reset for two cycles, then idle with start low.
    @(negedge clk);
    tick("rst0");
    tick("rst1");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick("idle_after_rst");

    // Single start pulse, b_lsb constantly 1.
    b_lsb = 1'b1;
    start = 1'b1;
    done_cyc = 0;
    for (int k = 1; k <= 16; k++) begin
      tick("seq_b1");
      start = 1'b0;
      if (done && done_cyc == 0) done_cyc = k;
    end
    chk("seq_b1_done_cycle", done_cyc, 14);

    // b_lsb per ADD = 1,0,1,1: loadp only on 1st, 3rd, 4th ADD.
    pat = 4'b1101;
    ai = 0; lp_cnt = 0; done_cyc = 0;
    b_lsb = pat[0];
    start = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick("seq_pat");
      start = 1'b0;
      if (loadp) lp_cnt++;
      if (done && done_cyc == 0) done_cyc = k;
      if (at("A") && ai < 3) ai++;
      b_lsb = pat[ai];
    end
    chk("seq_pat_loadp_count", lp_cnt, 3);
    chk("seq_pat_done_cycle", done_cyc, 14);

    // start held high: operations begin every 3N+3 cycles.
    start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      b_lsb = 1'($urandom);
      tick("start_held");
      if (clr) clr_starts.push_back(k);
    end
    start = 1'b0;
    chk("held_op_count", clr_starts.size(), 3);
    if (clr_starts.size() == 3) begin
      chk("held_op1", clr_starts[0], 1);
      chk("held_op2", clr_starts[1], 16);
      chk("held_op3", clr_starts[2], 31);
    end
    for (int k = 0; k < 20; k++) tick("drain");

    // Random start and b_lsb traffic.
    for (int k = 0; k < 300; k++) begin
      start = ($urandom_range(0, 3) == 0);
      b_lsb = 1'($urandom);
      tick("random");
    end
    start = 1'b0;
    for (int k = 0; k < 20; k++) tick("drain");

    // Reset during the second SHB aborts without a done pulse.
    start = 1'b1;
    nb = 0;
    for (int k = 0; k < 20 && nb < 2; k++) begin
      tick("pre_abort");
      start = 1'b0;
      if (at("B")) nb++;
    end
    chk("abort_reached_shb2", nb, 2);
    rst = 1'b1;
    tick("abort_rst");
    rst = 1'b0;
    chk("abort_idle_outputs", {clr, loadab, loadp, shftp, shftb, busy, done}, 7'd0);
    tick("abort_idle");
    start = 1'b1;
    done_cyc = 0;
    for (int k = 1; k <= 16; k++) begin
      tick("post_abort");
      start = 1'b0;
      if (k == 1) chk("post_abort_clr_first", clr, 1'b1);
      if (done && done_cyc == 0) done_cyc = k;
    end
    chk("post_abort_done_cycle", done_cyc, 14);

    // N=8, no skipping, b_lsb=0: 8 loadp, 8 shftp, 7 shftb, done at 3N+2.
    b8 = 1'b0;
    start8 = 1'b1;
    c_lp = 0; c_sp = 0; c_sb = 0; c_clr = 0; c_dn = 0; k8 = 0;
    for (int k = 1; k <= 30; k++) begin
      tick("n8_idle_main");
      start8 = 1'b0;
      c_lp += int'(loadp8);
      c_sp += int'(shftp8);
      c_sb += int'(shftb8);
      c_clr += int'(clr8);
      c_dn += int'(done8);
      if (done8 && k8 == 0) k8 = k;
    end
    chk("n8_loadp", c_lp, 8);
    chk("n8_shftp", c_sp, 8);
    chk("n8_shftb", c_sb, 7);
    chk("n8_clr", c_clr, 1);
    chk("n8_done_count", c_dn, 1);
    chk("n8_done_cycle", k8, 26);
    chk("n8_idle_after", {clr8, loadab8, loadp8, shftp8, shftb8, busy8, done8}, 7'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
